seq_magnitude_comparator: RTL and testbench

//  Multi-cycle, parametrised magnitude comparator for the processor datapath (ALU compare / branch-condition unit).

---
 rtl/seq_magnitude_comparator.sv | 155 +++++++++++++++
 tb/tb_seq_magnitude_comparator.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks the operands CHUNK bits per cycle from the MSB end
// and stops at the first differing chunk, producing a registered one-hot gt/lt/eq result.
module seq_magnitude_comparator #(
    parameter  int WIDTH  = 18,
    parameter  int CHUNK  = 6,
    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK,
    localparam int CW     = $clog2(NCHUNK + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_en,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             lt,
    output logic             eq,
    output logic [CW-1:0]    cycles
);

    localparam int PW = NCHUNK * CHUNK;
    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMP,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   a_q, a_d;
    logic [PW-1:0]   b_q, b_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            valid_q, valid_d;
    logic            gt_q, gt_d;
    logic            lt_q, lt_d;
    logic            eq_q, eq_d;
    logic [CW-1:0]   cycles_q, cycles_d;

    logic [WIDTH-1:0] a_adj;
    logic [WIDTH-1:0] b_adj;
    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;

    // Flipping the sign bit maps two's complement onto an order-preserving unsigned range.
    always_comb begin
        a_adj = a;
        b_adj = b;
        if (signed_en) begin
            a_adj[WIDTH-1] = ~a[WIDTH-1];
            b_adj[WIDTH-1] = ~b[WIDTH-1];
        end
    end

    assign chunk_a = a_q[idx_q*CHUNK +: CHUNK];
    assign chunk_b = b_q[idx_q*CHUNK +: CHUNK];

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        gt_d     = gt_q;
        lt_d     = lt_q;
        eq_d     = eq_q;
        cycles_d = cycles_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d      = PW'(a_adj);
                    b_d      = PW'(b_adj);
                    idx_d    = IW'(NCHUNK - 1);
                    cycles_d = '0;
                    state_d  = S_CMP;
                end
            end
            S_CMP: begin
                cycles_d = cycles_q + CW'(1);
                if (chunk_a != chunk_b) begin
                    gt_d    = (chunk_a > chunk_b);
                    lt_d    = (chunk_a < chunk_b);
                    valid_d = 1'b1;
                    state_d = S_DONE;
                end else if (idx_q == '0) begin
                    eq_d    = 1'b1;
                    valid_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    eq_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over both accept and completion.
        if (flush) begin
            state_d  = S_IDLE;
            valid_d  = 1'b0;
            gt_d     = 1'b0;
            lt_d     = 1'b0;
            eq_d     = 1'b0;
            cycles_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            valid_q  <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            gt_q     <= gt_d;
            lt_q     <= lt_d;
            eq_q     <= eq_d;
            cycles_q <= cycles_d;
        end
    end

    // NOTE: operand and index registers are left unreset; they are always loaded at accept before being read.
    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        idx_q <= idx_d;
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = valid_q;
    assign gt        = gt_q;
    assign lt        = lt_q;
    assign eq        = eq_q;
    assign cycles    = cycles_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench for seq_magnitude_comparator: default 18/6 instance plus an 18/4 instance
// for the padded-chunk case.
module tb_seq_magnitude_comparator;

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, signed_en, flush, out_valid, out_ready;
    logic [17:0] a, b;
    logic        gt, lt, eq;
    logic [1:0]  cycles;

    logic        in_valid4, in_ready4, signed_en4, flush4, out_valid4, out_ready4;
    logic [17:0] a4, b4;
    logic        gt4, lt4, eq4;
    logic [2:0]  cycles4;

    int n_checks;
    int n_fail;

    seq_magnitude_comparator #(.WIDTH(18), .CHUNK(6)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .signed_en(signed_en), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .gt(gt), .lt(lt), .eq(eq), .cycles(cycles)
    );

    seq_magnitude_comparator #(.WIDTH(18), .CHUNK(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
        .signed_en(signed_en4), .flush(flush4), .out_valid(out_valid4), .out_ready(out_ready4),
        .gt(gt4), .lt(lt4), .eq(eq4), .cycles(cycles4)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Launch one compare on the 18/6 instance, scramble inputs after accept, and
    // return the number of edges from accept to out_valid (20 = timed out).
    task automatic run_cmp(input logic [17:0] ta, input logic [17:0] tb_v, input logic ts,
                           output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        in_valid = 1'b1; a = ta; b = tb_v; signed_en = ts;
        @(posedge clk); #1;
        in_valid = 1'b0; a = ~ta; b = ~tb_v; signed_en = ~ts;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!out_valid && lat < 20);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({in_ready, out_valid, gt, lt, eq, cycles} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_state got rdy/ov/gt/lt/eq/cyc=%b required 1000000",
                     {in_ready, out_valid, gt, lt, eq, cycles});
        end
    endtask

    task automatic test_unsigned_gt();
        int lat;
        run_cmp(18'h3FFFF, 18'h00000, 1'b0, lat);
        n_checks++;
        if ({gt, lt, eq} !== 3'b100) begin
            n_fail++; $display("FAIL t1_result got gt/lt/eq=%b required 100", {gt, lt, eq});
        end
        n_checks++;
        if (lat !== 1 || cycles !== 2'd1) begin
            n_fail++; $display("FAIL t1_timing got lat=%0d cycles=%0d required lat=1 cycles=1", lat, cycles);
        end
        release_result();
    endtask

    task automatic test_equal();
        int lat;
        run_cmp(18'h12345, 18'h12345, 1'b0, lat);
        n_checks++;
        if ({gt, lt, eq} !== 3'b001) begin
            n_fail++; $display("FAIL t2_result got gt/lt/eq=%b required 001", {gt, lt, eq});
        end
        n_checks++;
        if (lat !== 3 || cycles !== 2'd3) begin
            n_fail++; $display("FAIL t2_timing got lat=%0d cycles=%0d required lat=3 cycles=3", lat, cycles);
        end
        release_result();
    endtask

    task automatic test_signed();
        int lat;
        run_cmp(18'h20000, 18'h00001, 1'b1, lat);
        n_checks++;
        if ({gt, lt, eq} !== 3'b010 || lat !== 1) begin
            n_fail++; $display("FAIL t3_signed got gt/lt/eq=%b lat=%0d required 010 lat=1", {gt, lt, eq}, lat);
        end
        release_result();
        run_cmp(18'h20000, 18'h00001, 1'b0, lat);
        n_checks++;
        if ({gt, lt, eq} !== 3'b100 || lat !== 1) begin
            n_fail++; $display("FAIL t3_unsigned got gt/lt/eq=%b lat=%0d required 100 lat=1", {gt, lt, eq}, lat);
        end
        release_result();
        // +131071 vs -131072 in signed mode
        run_cmp(18'h1FFFF, 18'h20000, 1'b1, lat);
        n_checks++;
        if ({gt, lt, eq} !== 3'b100 || cycles !== 2'd1) begin
            n_fail++; $display("FAIL t3_signed_pos got gt/lt/eq=%b cycles=%0d required 100 cycles=1", {gt, lt, eq}, cycles);
        end
        release_result();
    endtask

    task automatic test_lsb_diff();
        int lat;
        run_cmp(18'h00001, 18'h00000, 1'b0, lat);
        n_checks++;
        if ({gt, lt, eq} !== 3'b100 || cycles !== 2'd3 || lat !== 3) begin
            n_fail++; $display("FAIL t4_chunk6 got gt/lt/eq=%b cycles=%0d lat=%0d required 100 cycles=3 lat=3",
                               {gt, lt, eq}, cycles, lat);
        end
        release_result();

        in_valid4 = 1'b1; a4 = 18'h00001; b4 = 18'h00000; signed_en4 = 1'b0;
        @(posedge clk); #1;
        in_valid4 = 1'b0; a4 = 18'h0; b4 = 18'h3FFFF;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!out_valid4 && lat < 20);
        n_checks++;
        if ({gt4, lt4, eq4} !== 3'b100 || cycles4 !== 3'd5 || lat !== 5) begin
            n_fail++; $display("FAIL t4_chunk4 got gt/lt/eq=%b cycles=%0d lat=%0d required 100 cycles=5 lat=5",
                               {gt4, lt4, eq4}, cycles4, lat);
        end
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
        n_checks++;
        if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
            n_fail++; $display("FAIL t4_chunk4_release got ov=%b rdy=%b required ov=0 rdy=1", out_valid4, in_ready4);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        // chunk 2 equal (0), chunk 1: 4 vs 8
        run_cmp(18'h00100, 18'h00200, 1'b0, lat);
        n_checks++;
        if ({gt, lt, eq} !== 3'b010 || cycles !== 2'd2 || lat !== 2) begin
            n_fail++; $display("FAIL t5_result got gt/lt/eq=%b cycles=%0d lat=%0d required 010 cycles=2 lat=2",
                               {gt, lt, eq}, cycles, lat);
        end
        for (int i = 0; i < 5; i++) begin
            a = 18'($urandom); b = 18'($urandom); signed_en = i[0];
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid, in_ready, gt, lt, eq, cycles} !== 7'b1001010) begin
                n_fail++; $display("FAIL t5_hold[%0d] got ov/rdy/gt/lt/eq/cyc=%b required 1001010",
                                   i, {out_valid, in_ready, gt, lt, eq, cycles});
            end
        end
        release_result();
        n_checks++;
        if ({out_valid, gt, lt, eq} !== 4'b0000 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL t5_release got ov/gt/lt/eq=%b rdy=%b required 0000 rdy=1",
                               {out_valid, gt, lt, eq}, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        run_cmp(18'h00005, 18'h00005, 1'b1, lat);
        n_checks++;
        if ({gt, lt, eq} !== 3'b001 || lat !== 3) begin
            n_fail++; $display("FAIL b2b_result got gt/lt/eq=%b lat=%0d required 001 lat=3", {gt, lt, eq}, lat);
        end
        release_result();
    endtask

    task automatic test_flush();
        int lat;
        // flush mid-CMP on a long compare
        in_valid = 1'b1; a = 18'h0AAAA; b = 18'h0AAAA; signed_en = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_checks++;
        if ({in_ready, out_valid, gt, lt, eq, cycles} !== 7'b1000000) begin
            n_fail++; $display("FAIL flush_mid got rdy/ov/gt/lt/eq/cyc=%b required 1000000",
                               {in_ready, out_valid, gt, lt, eq, cycles});
        end
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_stays_idle got ov=%b required 0", out_valid);
        end
        // flush in the completing cycle beats completion
        in_valid = 1'b1; a = 18'h3FFFF; b = 18'h00000;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_vs_done got ov=%b rdy=%b required ov=0 rdy=1", out_valid, in_ready);
        end
        // flush in IDLE beats accept
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_vs_accept got rdy=%b required 1", in_ready);
        end
        run_cmp(18'h00010, 18'h00020, 1'b0, lat);
        n_checks++;
        if ({gt, lt, eq} !== 3'b010 || cycles !== 2'd3 || lat !== 3) begin
            n_fail++; $display("FAIL flush_recover got gt/lt/eq=%b cycles=%0d lat=%0d required 010 cycles=3 lat=3",
                               {gt, lt, eq}, cycles, lat);
        end
        release_result();
    endtask

    task automatic test_reset_mid();
        int lat;
        in_valid = 1'b1; a = 18'h12345; b = 18'h12345; signed_en = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, out_valid, gt, lt, eq, cycles} !== 7'b1000000) begin
            n_fail++; $display("FAIL rst_mid_cmp got rdy/ov/gt/lt/eq/cyc=%b required 1000000",
                               {in_ready, out_valid, gt, lt, eq, cycles});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        // asynchronous clear of a held result, between clock edges
        run_cmp(18'h3FFFF, 18'h00000, 1'b0, lat);
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, out_valid, gt, lt, eq, cycles} !== 7'b1000000) begin
            n_fail++; $display("FAIL rst_in_done got rdy/ov/gt/lt/eq/cyc=%b required 1000000",
                               {in_ready, out_valid, gt, lt, eq, cycles});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        run_cmp(18'h00040, 18'h00000, 1'b0, lat);
        n_checks++;
        if ({gt, lt, eq} !== 3'b100 || cycles !== 2'd2 || lat !== 2) begin
            n_fail++; $display("FAIL rst_recover got gt/lt/eq=%b cycles=%0d lat=%0d required 100 cycles=2 lat=2",
                               {gt, lt, eq}, cycles, lat);
        end
        release_result();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        clk       = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0; a  = '0; b  = '0; signed_en  = 1'b0; flush  = 1'b0; out_ready  = 1'b0;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; signed_en4 = 1'b0; flush4 = 1'b0; out_ready4 = 1'b0;
        #2;
        test_reset();
        #10 rst = 1'b0;
        @(posedge clk); #1;
        test_unsigned_gt();
        test_equal();
        test_signed();
        test_lsb_diff();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
